// File: rtl/interp_seq_ctrl_if.sv
// Handshake and control bundle between the estimation top, the pilot buffer,
// the interpolation datapath and the interpolation sequencer.
interface interp_seq_ctrl_if #(
  parameter int NP_W = 4,
  parameter int SC_W = 7
);
  logic            start;
  logic [NP_W-1:0] n_pairs;
  logic            out_ready;
  logic            pilot_rd;
  logic [NP_W-1:0] pilot_addr0;
  logic [NP_W-1:0] pilot_addr1;
  logic [1:0]      add1_sel;
  logic [1:0]      add2_sel;
  logic            en_reg_E;
  logic            en_reg_2E;
  logic            en_reg_5E;
  logic [2:0]      mult_sel;
  logic            out_valid;
  logic [SC_W-1:0] out_idx;
  logic            busy;
  logic            done;

  modport master (
    output start, n_pairs, out_ready,
    input  pilot_rd, pilot_addr0, pilot_addr1, add1_sel, add2_sel,
           en_reg_E, en_reg_2E, en_reg_5E, mult_sel, out_valid, out_idx,
           busy, done
  );

  modport slave (
    input  start, n_pairs, out_ready,
    output pilot_rd, pilot_addr0, pilot_addr1, add1_sel, add2_sel,
           en_reg_E, en_reg_2E, en_reg_5E, mult_sel, out_valid, out_idx,
           busy, done
  );
endinterface

// File: rtl/interp_seq_ctrl.sv
// Sequencer for pilot-pair linear interpolation: loads E/2E/5E, then emits the
// five interpolated subcarriers between each pilot pair under valid/ready.
module interp_seq_ctrl #(
  parameter int NP_W = 4,
  parameter int SC_W = 7
) (
  input logic              clk,
  input logic              rst,
  interp_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_CALC_E, S_CALC_2E, S_CALC_5E, S_EMIT, S_DONE
  } state_t;

  state_t          r_state;
  logic [NP_W-1:0] r_p;
  logic [NP_W-1:0] r_np;
  logic            r_pilot_rd;
  logic [NP_W-1:0] r_addr0;
  logic [NP_W-1:0] r_addr1;
  logic [1:0]      r_add1_sel;
  logic [1:0]      r_add2_sel;
  logic            r_en_E;
  logic            r_en_2E;
  logic            r_en_5E;
  logic [2:0]      r_mult;
  logic            r_valid;
  logic [SC_W-1:0] r_idx;
  logic            r_busy;
  logic            r_done;

  logic [SC_W-1:0] w_six_p;
  logic            w_last_pair;

  assign w_six_p     = (SC_W'(r_p) << 2) + (SC_W'(r_p) << 1);
  assign w_last_pair = ((r_p + NP_W'(1)) == r_np);

  // Outputs are loaded together with the state they belong to; r_mult doubles as k.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_p        <= '0;
      r_np       <= '0;
      r_pilot_rd <= 1'b0;
      r_addr0    <= '0;
      r_addr1    <= '0;
      r_add1_sel <= 2'd0;
      r_add2_sel <= 2'd0;
      r_en_E     <= 1'b0;
      r_en_2E    <= 1'b0;
      r_en_5E    <= 1'b0;
      r_mult     <= 3'd0;
      r_valid    <= 1'b0;
      r_idx      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_pilot_rd <= 1'b0;
      r_addr0    <= '0;
      r_addr1    <= '0;
      r_add1_sel <= 2'd0;
      r_add2_sel <= 2'd0;
      r_en_E     <= 1'b0;
      r_en_2E    <= 1'b0;
      r_en_5E    <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_np <= bus.n_pairs;
            r_p  <= '0;
            if (bus.n_pairs == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= S_RD;
              r_busy     <= 1'b1;
              r_pilot_rd <= 1'b1;
              r_addr1    <= NP_W'(1);
            end
          end
        end
        S_RD: begin
          r_state    <= S_CALC_E;
          r_add1_sel <= 2'd1;
          r_en_E     <= 1'b1;
        end
        S_CALC_E: begin
          r_state    <= S_CALC_2E;
          r_add1_sel <= 2'd2;
          r_en_2E    <= 1'b1;
        end
        S_CALC_2E: begin
          r_state    <= S_CALC_5E;
          r_add2_sel <= 2'd1;
          r_en_5E    <= 1'b1;
        end
        S_CALC_5E: begin
          r_state    <= S_EMIT;
          r_add2_sel <= 2'd2;
          r_mult     <= 3'd1;
          r_valid    <= 1'b1;
          r_idx      <= w_six_p + SC_W'(1);
        end
        S_EMIT: begin
          r_add2_sel <= 2'd2;
          if (bus.out_ready) begin
            if (r_mult == 3'd5) begin
              r_add2_sel <= 2'd0;
              r_mult     <= 3'd0;
              r_valid    <= 1'b0;
              r_idx      <= '0;
              if (w_last_pair) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state    <= S_RD;
                r_p        <= r_p + NP_W'(1);
                r_pilot_rd <= 1'b1;
                r_addr0    <= r_p + NP_W'(1);
                r_addr1    <= r_p + NP_W'(2);
              end
            end else begin
              r_mult <= r_mult + 3'd1;
              r_idx  <= r_idx + SC_W'(1);
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pilot_rd    = r_pilot_rd;
  assign bus.pilot_addr0 = r_addr0;
  assign bus.pilot_addr1 = r_addr1;
  assign bus.add1_sel    = r_add1_sel;
  assign bus.add2_sel    = r_add2_sel;
  assign bus.en_reg_E    = r_en_E;
  assign bus.en_reg_2E   = r_en_2E;
  assign bus.en_reg_5E   = r_en_5E;
  assign bus.mult_sel    = r_mult;
  assign bus.out_valid   = r_valid;
  assign bus.out_idx     = r_idx;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;

endmodule
